// File: rtl/dct8_pkg.sv
// Shared constants and arithmetic helpers for the 8-point forward/inverse integer DCT.
// The helpers operate on a 64-bit signed intermediate so callers never wrap.
package dct8_pkg;

    localparam int DATA_W_DEF = 25;

    localparam int C64 = 64;
    localparam int C83 = 83;
    localparam int C36 = 36;
    localparam int C89 = 89;
    localparam int C75 = 75;
    localparam int C50 = 50;
    localparam int C18 = 18;

    // Floor of (v + 2^(sh-1)) / 2^sh; sh <= 0 passes v through unrounded.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                       input int sh);
        logic signed [63:0] r;
        if (sh <= 0) begin
            r = v;
        end else begin
            r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
        end
        return r;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/dct8_butterfly.sv
// Registered first stage of the forward DCT: even/odd butterfly of one 8-sample row.
// Holds its contents and valid bit while the downstream pipeline is stalled.
module dct8_butterfly
    import dct8_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x [8],
    output logic signed [DATA_W:0]   e [4],
    output logic signed [DATA_W:0]   o [4],
    output logic                     valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (!stall) begin
            valid <= in_valid;
            for (int k = 0; k < 4; k++) begin
                e[k] <= (DATA_W+1)'(x[k]) + (DATA_W+1)'(x[7-k]);
                o[k] <= (DATA_W+1)'(x[k]) - (DATA_W+1)'(x[7-k]);
            end
        end
    end

endmodule

// File: rtl/dct8_forward.sv
// Three-stage pipelined 8-point forward integer DCT (HEVC coefficients) with a
// valid/ready handshake; a stalled output freezes every stage of the pipeline.
module dct8_forward
    import dct8_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SHIFT  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] data_in_1,
    input  logic signed [DATA_W-1:0] data_in_2,
    input  logic signed [DATA_W-1:0] data_in_3,
    input  logic signed [DATA_W-1:0] data_in_4,
    input  logic signed [DATA_W-1:0] data_in_5,
    input  logic signed [DATA_W-1:0] data_in_6,
    input  logic signed [DATA_W-1:0] data_in_7,
    input  logic signed [DATA_W-1:0] data_in_8,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] data_out_1,
    output logic signed [DATA_W-1:0] data_out_2,
    output logic signed [DATA_W-1:0] data_out_3,
    output logic signed [DATA_W-1:0] data_out_4,
    output logic signed [DATA_W-1:0] data_out_5,
    output logic signed [DATA_W-1:0] data_out_6,
    output logic signed [DATA_W-1:0] data_out_7,
    output logic signed [DATA_W-1:0] data_out_8,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int MW = DATA_W + 12;

    localparam logic signed [MW-1:0] K64 = MW'(C64);
    localparam logic signed [MW-1:0] K83 = MW'(C83);
    localparam logic signed [MW-1:0] K36 = MW'(C36);
    localparam logic signed [MW-1:0] KO [4] = '{MW'(C89), MW'(C75), MW'(C50), MW'(C18)};

    logic signed [DATA_W-1:0] x [8];
    logic signed [DATA_W:0]   e [4];
    logic signed [DATA_W:0]   o [4];
    logic                     v1;
    logic                     v2;
    logic                     stall;

    // Handshake: a row transfers on in_valid & in_ready; coefficients transfer on
    // out_valid & out_ready. Only a held valid output stalls; bubbles always advance.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    assign x[0] = data_in_1;
    assign x[1] = data_in_2;
    assign x[2] = data_in_3;
    assign x[3] = data_in_4;
    assign x[4] = data_in_5;
    assign x[5] = data_in_6;
    assign x[6] = data_in_7;
    assign x[7] = data_in_8;

    dct8_butterfly #(
        .DATA_W(DATA_W)
    ) u_butterfly (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .in_valid(in_valid),
        .x       (x),
        .e       (e),
        .o       (o),
        .valid   (v1)
    );

    logic signed [MW-1:0] ee0_x;
    logic signed [MW-1:0] ee1_x;
    logic signed [MW-1:0] eo0_x;
    logic signed [MW-1:0] eo1_x;
    logic signed [MW-1:0] o_x [4];

    always_comb begin
        ee0_x = MW'((DATA_W+2)'(e[0]) + (DATA_W+2)'(e[3]));
        ee1_x = MW'((DATA_W+2)'(e[1]) + (DATA_W+2)'(e[2]));
        eo0_x = MW'((DATA_W+2)'(e[0]) - (DATA_W+2)'(e[3]));
        eo1_x = MW'((DATA_W+2)'(e[1]) - (DATA_W+2)'(e[2]));
        for (int k = 0; k < 4; k++) begin
            o_x[k] = MW'(o[k]);
        end
    end

    // Stage 2: every constant product registered; p_o[k][j] = O_k * {89,75,50,18}[j].
    logic signed [MW-1:0] p_ee0;
    logic signed [MW-1:0] p_ee1;
    logic signed [MW-1:0] p83_eo0;
    logic signed [MW-1:0] p36_eo0;
    logic signed [MW-1:0] p83_eo1;
    logic signed [MW-1:0] p36_eo1;
    logic signed [MW-1:0] p_o [4][4];

    always_ff @(posedge clk) begin
        if (reset) begin
            v2 <= 1'b0;
        end else if (!stall) begin
            v2      <= v1;
            p_ee0   <= ee0_x * K64;
            p_ee1   <= ee1_x * K64;
            p83_eo0 <= eo0_x * K83;
            p36_eo0 <= eo0_x * K36;
            p83_eo1 <= eo1_x * K83;
            p36_eo1 <= eo1_x * K36;
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 4; j++) begin
                    p_o[k][j] <= o_x[k] * KO[j];
                end
            end
        end
    end

    logic signed [MW-1:0]     y [8];
    logic signed [DATA_W-1:0] y_sat [8];

    always_comb begin
        y[0] = p_ee0 + p_ee1;
        y[4] = p_ee0 - p_ee1;
        y[2] = p83_eo0 + p36_eo1;
        y[6] = p36_eo0 - p83_eo1;
        y[1] = p_o[0][0] + p_o[1][1] + p_o[2][2] + p_o[3][3];
        y[3] = p_o[0][1] - p_o[1][3] - p_o[2][0] - p_o[3][2];
        y[5] = p_o[0][2] - p_o[1][0] + p_o[2][3] + p_o[3][1];
        y[7] = p_o[0][3] - p_o[1][2] + p_o[2][1] - p_o[3][0];
        for (int k = 0; k < 8; k++) begin
            y_sat[k] = DATA_W'(saturate(round_shift(64'(y[k]), SHIFT), DATA_W));
        end
    end

    // Output register only loads real rows, so bubbles leave the last result visible.
    logic signed [DATA_W-1:0] y_q [8];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                y_q[k] <= '0;
            end
        end else if (!stall) begin
            out_valid <= v2;
            if (v2) begin
                for (int k = 0; k < 8; k++) begin
                    y_q[k] <= y_sat[k];
                end
            end
        end
    end

    assign data_out_1 = y_q[0];
    assign data_out_2 = y_q[1];
    assign data_out_3 = y_q[2];
    assign data_out_4 = y_q[3];
    assign data_out_5 = y_q[4];
    assign data_out_6 = y_q[5];
    assign data_out_7 = y_q[6];
    assign data_out_8 = y_q[7];

endmodule

// File: tb/tb_dct8_forward.sv
// Directed bench for dct8_forward: reset, DC, impulses, saturation, backpressure
// stream against a full-matrix reference, and reset with rows in flight.
module tb_dct8_forward;

    localparam int DW = 25;

    // Full HEVC 8-point forward matrix, row k gives coefficient Yk.
    localparam int CM [8][8] = '{
        '{ 64,  64,  64,  64,  64,  64,  64,  64},
        '{ 89,  75,  50,  18, -18, -50, -75, -89},
        '{ 83,  36, -36, -83, -83, -36,  36,  83},
        '{ 75, -18, -89, -50,  50,  89,  18, -75},
        '{ 64, -64, -64,  64,  64, -64, -64,  64},
        '{ 50, -89,  18,  75, -75, -18,  89, -50},
        '{ 36, -83,  83, -36, -36,  83, -83,  36},
        '{ 18, -50,  75, -89,  89, -75,  50, -18}
    };

    logic clk = 1'b0;
    logic reset;
    logic signed [DW-1:0] din [8];
    logic signed [DW-1:0] dout [8];
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    int checks = 0;
    int failures = 0;
    logic [8*DW-1:0] exp_q[$];
    longint cur_x [8];
    longint want [8];
    longint bp_x [5][8];

    always #5 clk = ~clk;

    dct8_forward #(
        .DATA_W(DW),
        .SHIFT (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in_1 (din[0]),
        .data_in_2 (din[1]),
        .data_in_3 (din[2]),
        .data_in_4 (din[3]),
        .data_in_5 (din[4]),
        .data_in_6 (din[5]),
        .data_in_7 (din[6]),
        .data_in_8 (din[7]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out_1(dout[0]),
        .data_out_2(dout[1]),
        .data_out_3(dout[2]),
        .data_out_4(dout[3]),
        .data_out_5(dout[4]),
        .data_out_6(dout[5]),
        .data_out_7(dout[6]),
        .data_out_8(dout[7]),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint model_y(input int k);
        longint acc;
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            acc += longint'(CM[k][n]) * cur_x[n];
        end
        acc = (acc + 2) >>> 2;
        if (acc > 16777215) acc = 16777215;
        if (acc < -16777216) acc = -16777216;
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cur();
        for (int k = 0; k < 8; k++) begin
            din[k] = DW'(cur_x[k]);
        end
    endtask

    task automatic check_want(input string tag);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_y%0d", tag, k), dout[k], want[k]);
        end
    endtask

    // One isolated row: accepted at the first edge, result visible after the third.
    task automatic single_row(input string tag);
        drive_cur();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_early"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_in_ready_out"}, in_ready, 1);
        check_want(tag);
        tick();
        check({tag, "_drain"}, out_valid, 0);
    endtask

    initial begin
        logic [8*DW-1:0] e;
        int sent;
        int got;
        int stall_cnt;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) din[k] = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        for (int k = 0; k < 8; k++) check($sformatf("rst_y%0d", k), dout[k], 0);

        // DC row
        cur_x = '{100, 100, 100, 100, 100, 100, 100, 100};
        want  = '{12800, 0, 0, 0, 0, 0, 0, 0};
        single_row("dc");

        // Impulses
        cur_x = '{4, 0, 0, 0, 0, 0, 0, 0};
        want  = '{64, 89, 83, 75, 64, 50, 36, 18};
        single_row("imp_pos");
        cur_x = '{-4, 0, 0, 0, 0, 0, 0, 0};
        want  = '{-64, -89, -83, -75, -64, -50, -36, -18};
        single_row("imp_neg");

        // Saturation at both rails
        cur_x = '{16777215, 16777215, 16777215, 16777215,
                  16777215, 16777215, 16777215, 16777215};
        want  = '{16777215, 0, 0, 0, 0, 0, 0, 0};
        single_row("sat_pos");
        cur_x = '{-16777216, -16777216, -16777216, -16777216,
                  -16777216, -16777216, -16777216, -16777216};
        want  = '{-16777216, 0, 0, 0, 0, 0, 0, 0};
        single_row("sat_neg");

        // Backpressure: 5 back-to-back rows, out_ready low for cycles 4..7
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 8; k++) begin
                bp_x[r][k] = longint'((r + 1) * (k * 13 - 40) + r * r * 5 - (k % 3) * 7);
            end
        end
        sent = 0;
        got = 0;
        stall_cnt = 0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            if (sent < 5) begin
                cur_x = bp_x[sent];
                drive_cur();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", in_ready, (out_valid && !out_ready) ? 0 : 1);
            if (!in_ready) stall_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("bp_unexpected_row", 1, 0);
                end else begin
                    e = exp_q[0];
                    for (int k = 0; k < 8; k++) begin
                        check($sformatf("bp_row%0d_y%0d", got, k), dout[k],
                              longint'(signed'(e[k*DW +: DW])));
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = '0;
                for (int k = 0; k < 8; k++) e[k*DW +: DW] = DW'(model_y(k));
                exp_q.push_back(e);
                sent++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_rows_out", got, 5);
        check("bp_leftover", exp_q.size(), 0);
        check("bp_stall_cycles", stall_cnt, 4);
        tick();
        check("bp_idle", out_valid, 0);

        // Reset with two rows in flight
        cur_x = bp_x[1];
        drive_cur();
        in_valid = 1'b1;
        tick();
        cur_x = bp_x[2];
        drive_cur();
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        for (int k = 0; k < 8; k++) check($sformatf("midrst_y%0d", k), dout[k], 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("midrst_stale%0d", i), out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
